// File: rtl/sdff_ift_seq_ctrl.sv
// Sequencer: walks every {D,SRST} step of NVEC taint vectors into the IFT flip-flop and streams Q/Q_t.
// Latency: 1 load per vector, then HOLD+2 cycles per step plus any wait for res_ready.
// Backpressure: res_valid & !res_ready freezes res_data and all dut_* outputs; no step is skipped.
module sdff_ift_seq_ctrl #(
    parameter int DW   = 2,
    parameter int TW   = 32,
    parameter int NVEC = 4,
    parameter int HOLD = 2,
    localparam int VIW = (NVEC > 1) ? $clog2(NVEC) : 1,
    localparam int RW  = VIW + DW + 1 + DW + TW
) (
    input  logic              CLK,
    input  logic              ARST_N,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic              vec_we,
    input  logic [VIW-1:0]    vec_waddr,
    input  logic [2*TW-1:0]   vec_wdata,
    output logic [DW-1:0]     dut_d,
    output logic [TW-1:0]     dut_d_t,
    output logic              dut_srst,
    output logic [TW-1:0]     dut_srst_t,
    input  logic [DW-1:0]     dut_q,
    input  logic [TW-1:0]     dut_q_t,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RW-1:0]     res_data
);

    localparam int SW  = DW + 1;
    localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;

    if (HOLD < 2) begin : g_hold_chk
        $error("HOLD must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRIVE  = 3'd2,
        SAMPLE = 3'd3,
        EMIT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic [VIW-1:0]  vec_idx;
    logic [SW-1:0]   s;
    logic [SW-1:0]   s_inc;
    logic [HCW-1:0]  hc;
    logic            s_last, v_last, hc_last, aborting;

    logic [2*TW-1:0] vec_ram [1 << VIW];

    assign s_inc    = s + SW'(1);
    assign s_last   = (s == {SW{1'b1}});
    assign v_last   = (vec_idx == VIW'(NVEC - 1));
    assign hc_last  = (hc == HCW'(HOLD - 1));
    assign aborting = abort && (state != IDLE);

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    // RAM is deliberately not reset; writes only land while idle.
    always_ff @(posedge CLK) begin
        if (state == IDLE && vec_we) begin
            vec_ram[vec_waddr] <= vec_wdata;
        end
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !abort) state_nxt = LOAD;
            LOAD:    state_nxt = DRIVE;
            DRIVE:   if (hc_last) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = EMIT;
            EMIT: begin
                if (res_valid && res_ready) begin
                    if (!s_last)      state_nxt = DRIVE;
                    else if (!v_last) state_nxt = LOAD;
                    else              state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (aborting) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            vec_idx    <= '0;
            s          <= '0;
            hc         <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            dut_d      <= '0;
            dut_srst   <= 1'b0;
            dut_d_t    <= '0;
            dut_srst_t <= '0;
        end else if (aborting) begin
            vec_idx    <= '0;
            s          <= '0;
            hc         <= '0;
            res_valid  <= 1'b0;
            dut_d      <= '0;
            dut_srst   <= 1'b0;
            dut_d_t    <= '0;
            dut_srst_t <= '0;
        end else begin
            case (state)
                IDLE: begin
                    vec_idx <= '0;
                    s       <= '0;
                    hc      <= '0;
                end
                LOAD: begin
                    {dut_srst_t, dut_d_t} <= vec_ram[vec_idx];
                    dut_d    <= s[DW:1];
                    dut_srst <= s[0];
                    hc       <= '0;
                end
                DRIVE: begin
                    hc <= hc_last ? '0 : hc + HCW'(1);
                end
                SAMPLE: begin
                    res_data  <= {vec_idx, s, dut_q, dut_q_t};
                    res_valid <= 1'b1;
                end
                EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (!s_last) begin
                            s        <= s_inc;
                            dut_d    <= s_inc[DW:1];
                            dut_srst <= s_inc[0];
                            hc       <= '0;
                        end else if (!v_last) begin
                            vec_idx <= vec_idx + VIW'(1);
                            s       <= '0;
                        end
                    end
                end
                DONE: begin
                    // Leave the flip-flop quiet between runs.
                    dut_d      <= '0;
                    dut_srst   <= 1'b0;
                    dut_d_t    <= '0;
                    dut_srst_t <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdff_ift_seq_ctrl.sv
// Bench for sdff_ift_seq_ctrl with a behavioural IFT sync-reset flip-flop on the DUT side.
// Directed scenarios: reset, full run, backpressure, illegal requests, abort/restart.
module tb_sdff_ift_seq_ctrl;

    localparam int DW   = 2;
    localparam int TW   = 32;
    localparam int NVEC = 4;
    localparam int HOLD = 2;
    localparam int VIW  = 2;
    localparam int RW   = VIW + DW + 1 + DW + TW;
    localparam int NS   = 8;

    logic            CLK = 1'b0;
    logic            ARST_N = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            vec_we = 1'b0;
    logic [VIW-1:0]  vec_waddr = '0;
    logic [2*TW-1:0] vec_wdata = '0;
    logic            res_ready = 1'b1;
    logic            busy, done, dut_srst, res_valid;
    logic [DW-1:0]   dut_d;
    logic [TW-1:0]   dut_d_t, dut_srst_t;
    logic [RW-1:0]   res_data;
    logic [DW-1:0]   q_m = '0;
    logic [TW-1:0]   qt_m = '0;

    logic [RW-1:0]   resq [$];
    int              n_vec = 0;
    int              n_miss = 0;
    int              done_cnt = 0;
    int              busy_cnt = 0;
    bit              ok;

    // {SRST_t, D_t}; vector 2 is all-zero taint.
    logic [2*TW-1:0] vtab [NVEC] = '{
        {32'h0000_0000, 32'h0000_0001},
        {32'h0000_00F0, 32'h0000_0A00},
        {32'h0000_0000, 32'h0000_0000},
        {32'h8000_0000, 32'h0001_0001}
    };
    logic [DW-1:0] q_hand [NS] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0};

    sdff_ift_seq_ctrl #(.DW(DW), .TW(TW), .NVEC(NVEC), .HOLD(HOLD)) u_dut (
        .CLK        (CLK),
        .ARST_N     (ARST_N),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .vec_we     (vec_we),
        .vec_waddr  (vec_waddr),
        .vec_wdata  (vec_wdata),
        .dut_d      (dut_d),
        .dut_d_t    (dut_d_t),
        .dut_srst   (dut_srst),
        .dut_srst_t (dut_srst_t),
        .dut_q      (q_m),
        .dut_q_t    (qt_m),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
    );

    always #5 CLK = ~CLK;

    // Precise taint for Q <= SRST ? 0 : D: SRST taint matters only when D would survive.
    function automatic logic [TW-1:0] ift_qt(logic [DW-1:0] d, logic srst,
                                             logic [TW-1:0] dt, logic [TW-1:0] st);
        logic [TW-1:0] r;
        r = srst ? '0 : dt;
        if (d != '0) r = r | st;
        return r;
    endfunction

    function automatic logic [RW-1:0] exp_res(int v, int st);
        logic [DW-1:0] d;
        logic          sr;
        logic [DW-1:0] q;
        d  = DW'(st >> 1);
        sr = st[0];
        q  = sr ? '0 : d;
        return {VIW'(v), 3'(st), q, ift_qt(d, sr, vtab[v][TW-1:0], vtab[v][2*TW-1:TW])};
    endfunction

    always @(posedge CLK) begin
        q_m  <= dut_srst ? '0 : dut_d;
        qt_m <= ift_qt(dut_d, dut_srst, dut_d_t, dut_srst_t);
    end

    always @(negedge CLK) begin
        if (ARST_N) begin
            if (res_valid && res_ready && !abort) resq.push_back(res_data);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic pulse_start();
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
    endtask

    task automatic write_vec(input logic [VIW-1:0] a, input logic [2*TW-1:0] d);
        @(posedge CLK); #1;
        vec_we = 1'b1; vec_waddr = a; vec_wdata = d;
        @(posedge CLK); #1;
        vec_we = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK); #1;
            if (done) begin
                hit = 1'b1;
                break;
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic wait_count(input int n, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (resq.size() >= n) begin
                hit = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic wait_valid(input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (res_valid) begin
                hit = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        n_vec++;
        if ({busy, done, res_valid, dut_d, dut_srst, dut_d_t, dut_srst_t} !== '0) begin
            n_miss++;
            $display("FAIL reset_state: busy=%b done=%b vld=%b d=%h srst=%b dt=%h st=%h, want all 0",
                     busy, done, res_valid, dut_d, dut_srst, dut_d_t, dut_srst_t);
        end
        ARST_N = 1'b1;
        for (int v = 0; v < 3; v++) write_vec(VIW'(v), vtab[v]);
        write_vec(2'd3, 64'hDEAD_BEEF_0BAD_F00D);
        resq.delete();
        pulse_start();
        wait_count(8, 300, ok);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL reset_reach_vec1: got %0d results, want 8", resq.size());
        end
        @(posedge CLK); #1;
        n_vec++;
        if (dut_d_t !== vtab[1][TW-1:0] || !busy) begin
            n_miss++;
            $display("FAIL reset_in_vec1_drive: dt=%h busy=%b, want %h busy=1", dut_d_t, busy, vtab[1][TW-1:0]);
        end
        ARST_N = 1'b0;
        #2;
        n_vec++;
        if ({busy, res_valid, dut_d, dut_srst, dut_d_t, dut_srst_t} !== '0) begin
            n_miss++;
            $display("FAIL reset_async_clear: busy=%b vld=%b d=%h srst=%b dt=%h st=%h, want all 0",
                     busy, res_valid, dut_d, dut_srst, dut_d_t, dut_srst_t);
        end
        @(posedge CLK); #1;
        ARST_N = 1'b1;
    endtask

    // Also writes vector 3 in the same idle cycle as start: the run must see the new data.
    task automatic test_full_run();
        resq.delete();
        done_cnt = 0;
        busy_cnt = 0;
        res_ready = 1'b1;
        @(posedge CLK); #1;
        start = 1'b1; vec_we = 1'b1; vec_waddr = 2'd3; vec_wdata = vtab[3];
        @(posedge CLK); #1;
        start = 1'b0; vec_we = 1'b0;
        wait_done(400, ok);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL full_done_timeout: done not seen, want done pulse");
        end
        n_vec++;
        if (resq.size() !== 32) begin
            n_miss++;
            $display("FAIL full_count: got %0d results, want 32", resq.size());
        end
        for (int i = 0; i < NS && i < resq.size(); i++) begin
            n_vec++;
            if (resq[i][TW+DW-1:TW] !== q_hand[i]) begin
                n_miss++;
                $display("FAIL full_q_vec0[%0d]: got %0d, want %0d", i, resq[i][TW+DW-1:TW], q_hand[i]);
            end
        end
        for (int v = 0; v < NVEC; v++)
            for (int st = 0; st < NS; st++)
                if (v * NS + st < resq.size()) begin
                    n_vec++;
                    if (resq[v*NS+st] !== exp_res(v, st)) begin
                        n_miss++;
                        $display("FAIL full_res[%0d]: got %h, want %h", v*NS+st, resq[v*NS+st], exp_res(v, st));
                    end
                end
        n_vec++;
        if (done_cnt !== 1) begin
            n_miss++;
            $display("FAIL full_done_pulses: got %0d, want 1", done_cnt);
        end
        n_vec++;
        if (busy_cnt !== NVEC * (1 + NS * (HOLD + 2))) begin
            n_miss++;
            $display("FAIL full_busy_cycles: got %0d, want %0d", busy_cnt, NVEC * (1 + NS * (HOLD + 2)));
        end
    endtask

    task automatic test_backpressure();
        resq.delete();
        done_cnt = 0;
        res_ready = 1'b1;
        pulse_start();
        wait_count(3, 200, ok);
        res_ready = 1'b0;
        wait_valid(50, ok);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL bp_valid_timeout: res_valid not seen, want 1");
        end
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (res_valid !== 1'b1 || res_data !== {2'd0, 3'd3, 2'd0, 32'h0} || dut_d !== 2'd1 || dut_srst !== 1'b1) begin
                n_miss++;
                $display("FAIL bp_hold[%0d]: vld=%b data=%h d=%h srst=%b, want 1/%h/1/1",
                         i, res_valid, res_data, dut_d, dut_srst, {2'd0, 3'd3, 2'd0, 32'h0});
            end
            @(posedge CLK); #1;
        end
        n_vec++;
        if (resq.size() !== 3) begin
            n_miss++;
            $display("FAIL bp_stall_count: got %0d results, want 3", resq.size());
        end
        res_ready = 1'b1;
        wait_done(400, ok);
        n_vec++;
        if (resq.size() !== 32) begin
            n_miss++;
            $display("FAIL bp_count: got %0d results, want 32", resq.size());
        end
        for (int v = 0; v < NVEC; v++)
            for (int st = 0; st < NS; st++)
                if (v * NS + st < resq.size()) begin
                    n_vec++;
                    if (resq[v*NS+st] !== exp_res(v, st)) begin
                        n_miss++;
                        $display("FAIL bp_res[%0d]: got %h, want %h", v*NS+st, resq[v*NS+st], exp_res(v, st));
                    end
                end
    endtask

    task automatic test_illegal_requests();
        resq.delete();
        done_cnt = 0;
        pulse_start();
        wait_count(10, 200, ok);
        start = 1'b1; vec_we = 1'b1; vec_waddr = 2'd2; vec_wdata = '1;
        @(posedge CLK); #1;
        start = 1'b0; vec_we = 1'b0;
        wait_done(400, ok);
        n_vec++;
        if (resq.size() !== 32) begin
            n_miss++;
            $display("FAIL ill_count: got %0d results, want 32", resq.size());
        end
        for (int v = 0; v < NVEC; v++)
            for (int st = 0; st < NS; st++)
                if (v * NS + st < resq.size()) begin
                    n_vec++;
                    if (resq[v*NS+st] !== exp_res(v, st)) begin
                        n_miss++;
                        $display("FAIL ill_res[%0d]: got %h, want %h", v*NS+st, resq[v*NS+st], exp_res(v, st));
                    end
                end
        n_vec++;
        if (done_cnt !== 1) begin
            n_miss++;
            $display("FAIL ill_done_pulses: got %0d, want 1", done_cnt);
        end
    endtask

    task automatic test_abort();
        resq.delete();
        done_cnt = 0;
        pulse_start();
        wait_count(16, 300, ok);
        @(posedge CLK); #1;
        n_vec++;
        if (dut_d_t !== vtab[2][TW-1:0] || dut_srst_t !== vtab[2][2*TW-1:TW]) begin
            n_miss++;
            $display("FAIL abort_old_vec2_taint: dt=%h st=%h, want %h %h",
                     dut_d_t, dut_srst_t, vtab[2][TW-1:0], vtab[2][2*TW-1:TW]);
        end
        wait_count(21, 200, ok);
        wait_valid(50, ok);
        n_vec++;
        if (!ok || res_data !== exp_res(2, 5)) begin
            n_miss++;
            $display("FAIL abort_at_v2s5: vld=%b data=%h, want 1/%h", res_valid, res_data, exp_res(2, 5));
        end
        abort = 1'b1;
        @(posedge CLK); #1;
        abort = 1'b0;
        n_vec++;
        if ({busy, res_valid, dut_d, dut_srst, dut_d_t, dut_srst_t} !== '0) begin
            n_miss++;
            $display("FAIL abort_clear: busy=%b vld=%b d=%h srst=%b dt=%h st=%h, want all 0",
                     busy, res_valid, dut_d, dut_srst, dut_d_t, dut_srst_t);
        end
        repeat (3) @(posedge CLK);
        #1;
        n_vec++;
        if (resq.size() !== 21 || done_cnt !== 0) begin
            n_miss++;
            $display("FAIL abort_no_handshake: results=%0d done=%0d, want 21 and 0", resq.size(), done_cnt);
        end
        resq.delete();
        pulse_start();
        wait_done(400, ok);
        n_vec++;
        if (resq.size() !== 32 || done_cnt !== 1) begin
            n_miss++;
            $display("FAIL abort_restart_count: results=%0d done=%0d, want 32 and 1", resq.size(), done_cnt);
        end
        for (int v = 0; v < NVEC; v++)
            for (int st = 0; st < NS; st++)
                if (v * NS + st < resq.size()) begin
                    n_vec++;
                    if (resq[v*NS+st] !== exp_res(v, st)) begin
                        n_miss++;
                        $display("FAIL abort_restart_res[%0d]: got %h, want %h", v*NS+st, resq[v*NS+st], exp_res(v, st));
                    end
                end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_backpressure();
        test_illegal_requests();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
